// File: rtl/exe_mem_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_stage
// Execute stage plus the EX/MEM pipeline register.
// Takes the decode/execute register outputs and applies operand forwarding.
// Computes the ALU result and resolves branches and jumps. Drives the PC
// redirect back to fetch, and registers the results into the memory stage.
//
// Ports:
//   CLK, RST_N          clock (rising edge), synchronous active-low reset
//   *E controls         execute-stage control bits, ResultSrcE, TypeE, ALUControlE
//   RD1E, RD2E          register file operands
//   PCE, ImmExtE        PC and immediate, used for the branch/jump target
//   PCPlus4E, RdE       link value and destination register
//   ForwardAE/BE        operand select: 00/11 = RDxE, 01 = ResultW, 10 = ALUResultM
//   ResultW             writeback-stage result used for forwarding
//   StallM, FlushM      hold / bubble the EX/MEM register (flush wins)
//   PCSrcE, PCTargetE   combinational redirect to fetch
//   *M outputs          registered memory-stage controls and data
// -----------------------------------------------------------------------------
module exe_mem_stage #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             JumpE,
   input  logic             JumpRegE,
   input  logic             BranchE,
   input  logic             ALUSrcE,
   input  logic             funct3LSBE,
   input  logic             funct3MSBE,
   input  logic [1:0]       ResultSrcE,
   input  logic [2:0]       TypeE,
   input  logic [3:0]       ALUControlE,
   input  logic [WIDTH-1:0] RD1E,
   input  logic [WIDTH-1:0] RD2E,
   input  logic [WIDTH-1:0] PCE,
   input  logic [WIDTH-1:0] ImmExtE,
   input  logic [WIDTH-1:0] PCPlus4E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [WIDTH-1:0] ResultW,
   input  logic             StallM,
   input  logic             FlushM,
   output logic             PCSrcE,
   output logic [WIDTH-1:0] PCTargetE,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             funct3LSBM,
   output logic             funct3MSBM,
   output logic [1:0]       ResultSrcM,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [WIDTH-1:0] PCPlus4M,
   output logic [4:0]       RdM
);

   typedef struct packed {
      logic             regWrite;
      logic [1:0]       resultSrc;
      logic             memWrite;
      logic             f3Lsb;
      logic             f3Msb;
      logic [WIDTH-1:0] aluResult;
      logic [WIDTH-1:0] writeData;
      logic [WIDTH-1:0] pcPlus4;
      logic [4:0]       rd;
   } exMemT;

   exMemT            exMem_d, exMem_q;
   logic [WIDTH-1:0] srcA, fwdB, srcB, aluResult, jumpSum;
   logic [4:0]       shamt;
   logic             branchEq, branchLtS, branchLtU, taken;

   // Forwarding muxes. The ALUResultM leg comes from the register below, so it
   // is a sequential path and not a combinational loop.
   always_comb begin
      srcA = RD1E;
      fwdB = RD2E;
      case (ForwardAE)
         2'b01:   srcA = ResultW;
         2'b10:   srcA = exMem_q.aluResult;
         default: srcA = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   fwdB = ResultW;
         2'b10:   fwdB = exMem_q.aluResult;
         default: fwdB = RD2E;
      endcase
   end

   assign srcB  = ALUSrcE ? ImmExtE : fwdB;
   assign shamt = srcB[4:0];

   // ALU. Add and subtract wrap silently. Unused opcodes produce zero.
   always_comb begin
      aluResult = '0;
      case (ALUControlE)
         4'b0000: aluResult = srcA + srcB;
         4'b0001: aluResult = srcA - srcB;
         4'b0010: aluResult = srcA & srcB;
         4'b0011: aluResult = srcA | srcB;
         4'b0100: aluResult = srcA ^ srcB;
         4'b0101: aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         4'b0110: aluResult = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         4'b0111: aluResult = srcA << shamt;
         4'b1000: aluResult = srcA >> shamt;
         4'b1001: aluResult = $signed(srcA) >>> shamt;
         4'b1010: aluResult = srcB;
         default: aluResult = '0;
      endcase
   end

   // The branch compare always uses the register operand (fwdB), never the
   // immediate, because branches encode their offset in ImmExtE.
   assign branchEq  = (srcA == fwdB);
   assign branchLtS = ($signed(srcA) < $signed(fwdB));
   assign branchLtU = (srcA < fwdB);

   // Branch condition decode on funct3. Codes 010 and 011 are never taken.
   always_comb begin
      taken = 1'b0;
      case (TypeE)
         3'b000:  taken = branchEq;
         3'b001:  taken = ~branchEq;
         3'b100:  taken = branchLtS;
         3'b101:  taken = ~branchLtS;
         3'b110:  taken = branchLtU;
         3'b111:  taken = ~branchLtU;
         default: taken = 1'b0;
      endcase
   end

   // Redirect is left ungated by stall/flush; the hazard unit qualifies it.
   // JALR clears bit 0 of its target.
   assign jumpSum   = srcA + ImmExtE;
   assign PCSrcE    = JumpE | (BranchE & taken);
   assign PCTargetE = JumpRegE ? {jumpSum[WIDTH-1:1], 1'b0} : (PCE + ImmExtE);

   // Next-state selection for EX/MEM. A flush overrides a stall, and a flush
   // yields a bubble with both write enables cleared. Store data is the
   // forwarded value, not raw RD2E.
   always_comb begin
      exMem_d = exMem_q;
      if (FlushM) begin
         exMem_d = '0;
      end else if (!StallM) begin
         exMem_d.regWrite  = RegWriteE;
         exMem_d.resultSrc = ResultSrcE;
         exMem_d.memWrite  = MemWriteE;
         exMem_d.f3Lsb     = funct3LSBE;
         exMem_d.f3Msb     = funct3MSBE;
         exMem_d.aluResult = aluResult;
         exMem_d.writeData = fwdB;
         exMem_d.pcPlus4   = PCPlus4E;
         exMem_d.rd        = RdE;
      end
   end

   // EX/MEM register. Reset takes priority over flush and stall.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         exMem_q <= '0;
      end else begin
         exMem_q <= exMem_d;
      end
   end

   assign RegWriteM  = exMem_q.regWrite;
   assign ResultSrcM = exMem_q.resultSrc;
   assign MemWriteM  = exMem_q.memWrite;
   assign funct3LSBM = exMem_q.f3Lsb;
   assign funct3MSBM = exMem_q.f3Msb;
   assign ALUResultM = exMem_q.aluResult;
   assign WriteDataM = exMem_q.writeData;
   assign PCPlus4M   = exMem_q.pcPlus4;
   assign RdM        = exMem_q.rd;

endmodule

// File: tb/tb_exe_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_mem_stage
// Directed testbench for exe_mem_stage. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_exe_mem_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE;
   logic        funct3LSBE, funct3MSBE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  TypeE;
   logic [3:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallM, FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, funct3LSBM, funct3MSBM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;

   int checkCount = 0;
   int failCount  = 0;

   exe_mem_stage #(.WIDTH(32)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .JumpRegE(JumpRegE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .funct3LSBE(funct3LSBE), .funct3MSBE(funct3MSBE),
      .ResultSrcE(ResultSrcE), .TypeE(TypeE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM),
      .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .funct3LSBM(funct3LSBM), .funct3MSBM(funct3MSBM),
      .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
   );

   // 10 ns clock.
   always #5 CLK = ~CLK;

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive an ALU-type instruction with no forwarding, no branch or jump.
   task automatic applyStimulus(input logic [3:0] aluCtl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic aluSrc, input logic [4:0] rd);
      ALUControlE = aluCtl;
      RD1E        = rd1;
      RD2E        = rd2;
      ImmExtE     = imm;
      ALUSrcE     = aluSrc;
      RdE         = rd;
      ForwardAE   = 2'b00;
      ForwardBE   = 2'b00;
      BranchE     = 1'b0;
      JumpE       = 1'b0;
      JumpRegE    = 1'b0;
      TypeE       = 3'b000;
      RegWriteE   = 1'b1;
      MemWriteE   = 1'b0;
      ResultSrcE  = 2'b00;
      funct3LSBE  = 1'b0;
      funct3MSBE  = 1'b0;
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Table for the ALU sweep with SrcA = 0x80000000, SrcB = 1.
   logic [3:0]  sweepOp  [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'h9, 4'hF};
   logic [31:0] sweepExp [11] = '{32'h80000001, 32'h7FFFFFFF, 32'h0, 32'h80000001,
                                  32'h80000001, 32'h1, 32'h0, 32'h0,
                                  32'h40000000, 32'hC0000000, 32'h0};

   logic [7:0] takenMask;

   initial begin
      // Reset with arbitrary, non-zero inputs.
      RST_N = 1'b0; StallM = 1'b0; FlushM = 1'b0; ResultW = 32'h0;
      PCE = 32'h0; PCPlus4E = 32'h4;
      applyStimulus(4'h0, 32'hABC, 32'h123, 32'h77, 1'b0, 5'd3);
      MemWriteE = 1'b1; ResultSrcE = 2'b10; funct3LSBE = 1'b1; funct3MSBE = 1'b1;
      tick();
      tick();
      checkOutput("rst_alu", ALUResultM, 32'h0);
      checkOutput("rst_regwr", {31'b0, RegWriteM}, 32'h0);
      checkOutput("rst_memwr", {31'b0, MemWriteM}, 32'h0);
      checkOutput("rst_rd", {27'b0, RdM}, 32'h0);
      checkOutput("rst_wdata", WriteDataM, 32'h0);
      checkOutput("rst_pc4", PCPlus4M, 32'h0);
      checkOutput("rst_rsrc", {30'b0, ResultSrcM}, 32'h0);
      checkOutput("rst_f3", {30'b0, funct3MSBM, funct3LSBM}, 32'h0);

      // First edge after release loads normally.
      RST_N = 1'b1;
      applyStimulus(4'h0, 32'd5, 32'd7, 32'h0, 1'b0, 5'd9);
      tick();
      checkOutput("first_add", ALUResultM, 32'd12);
      checkOutput("first_rd", {27'b0, RdM}, 32'd9);
      checkOutput("first_regwr", {31'b0, RegWriteM}, 32'h1);

      // ALU sweep.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(sweepOp[i], 32'h80000000, 32'h1, 32'h0, 1'b0, 5'd1);
         tick();
         checkOutput($sformatf("alu_op%0h", sweepOp[i]), ALUResultM, sweepExp[i]);
      end
      // LUI passes the immediate through as SrcB; store data is still FwdB.
      applyStimulus(4'hA, 32'h80000000, 32'h1, 32'h12345000, 1'b1, 5'd2);
      tick();
      checkOutput("alu_lui", ALUResultM, 32'h12345000);
      checkOutput("lui_wdata", WriteDataM, 32'h1);

      // Forwarding: first put 0x10 into ALUResultM.
      applyStimulus(4'h0, 32'h10, 32'h0, 32'h0, 1'b0, 5'd4);
      tick();
      applyStimulus(4'h0, 32'h1, 32'h55, 32'h0, 1'b0, 5'd4);
      ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01;
      tick();
      checkOutput("fwd_add", ALUResultM, 32'h30);
      checkOutput("fwd_wdata", WriteDataM, 32'h20);
      applyStimulus(4'h0, 32'h3, 32'h4, 32'h0, 1'b0, 5'd4);
      ForwardAE = 2'b11; ForwardBE = 2'b11;
      tick();
      checkOutput("fwd_11", ALUResultM, 32'h7);

      // Branch conditions with SrcA = -1, FwdB = 0; ALUSrcE set to show
      // the compare ignores the immediate.
      takenMask = 8'b1001_0010;
      applyStimulus(4'h1, 32'hFFFFFFFF, 32'h0, 32'h20, 1'b1, 5'd0);
      RegWriteE = 1'b0; BranchE = 1'b1; PCE = 32'h100;
      for (int t = 0; t < 8; t++) begin
         TypeE = 3'(t);
         #1;
         checkOutput($sformatf("br_type%0d", t), {31'b0, PCSrcE}, {31'b0, takenMask[t]});
      end
      TypeE = 3'b100;
      #1;
      checkOutput("br_target", PCTargetE, 32'h120);
      BranchE = 1'b0;
      #1;
      checkOutput("br_notbranch", {31'b0, PCSrcE}, 32'h0);
      BranchE = 1'b1; TypeE = 3'b000; RD1E = 32'h0;
      #1;
      checkOutput("br_beq", {31'b0, PCSrcE}, 32'h1);

      // JALR with RdE = 0 still loads.
      applyStimulus(4'h0, 32'h1003, 32'h0, 32'h4, 1'b1, 5'd0);
      JumpE = 1'b1; JumpRegE = 1'b1; PCE = 32'h500; PCPlus4E = 32'h504;
      #1;
      checkOutput("jalr_target", PCTargetE, 32'h1006);
      checkOutput("jalr_pcsrc", {31'b0, PCSrcE}, 32'h1);
      tick();
      checkOutput("jalr_pc4", PCPlus4M, 32'h504);
      checkOutput("jalr_regwr", {31'b0, RegWriteM}, 32'h1);

      // Valid store, then three stalled cycles with changing inputs.
      applyStimulus(4'h0, 32'h200, 32'hDEADBEEF, 32'h8, 1'b1, 5'd5);
      RegWriteE = 1'b0; MemWriteE = 1'b1; funct3LSBE = 1'b1; PCPlus4E = 32'h600;
      tick();
      checkOutput("st_alu", ALUResultM, 32'h208);
      checkOutput("st_wdata", WriteDataM, 32'hDEADBEEF);
      checkOutput("st_memwr", {31'b0, MemWriteM}, 32'h1);
      StallM = 1'b1;
      for (int s = 0; s < 3; s++) begin
         applyStimulus(4'h1, 32'(s + 1), 32'h99, 32'h0, 1'b0, 5'd7);
         JumpE = 1'b1;
         #1;
         checkOutput($sformatf("stall_pcsrc%0d", s), {31'b0, PCSrcE}, 32'h1);
         tick();
         checkOutput($sformatf("stall_alu%0d", s), ALUResultM, 32'h208);
         checkOutput($sformatf("stall_wdata%0d", s), WriteDataM, 32'hDEADBEEF);
         checkOutput($sformatf("stall_rd%0d", s), {27'b0, RdM}, 32'd5);
         checkOutput($sformatf("stall_memwr%0d", s), {31'b0, MemWriteM}, 32'h1);
      end
      FlushM = 1'b1;
      tick();
      checkOutput("flush_memwr", {31'b0, MemWriteM}, 32'h0);
      checkOutput("flush_regwr", {31'b0, RegWriteM}, 32'h0);
      checkOutput("flush_alu", ALUResultM, 32'h0);
      checkOutput("flush_wdata", WriteDataM, 32'h0);
      checkOutput("flush_pc4", PCPlus4M, 32'h0);
      checkOutput("flush_f3", {30'b0, funct3MSBM, funct3LSBM}, 32'h0);

      // Reset asserted during a stall clears state; next edge after release loads.
      FlushM = 1'b0; StallM = 1'b0;
      applyStimulus(4'h3, 32'hF0, 32'h0F, 32'h0, 1'b0, 5'd6);
      tick();
      checkOutput("pre_rst_or", ALUResultM, 32'hFF);
      StallM = 1'b1; RST_N = 1'b0;
      tick();
      checkOutput("rst_stall_alu", ALUResultM, 32'h0);
      checkOutput("rst_stall_rd", {27'b0, RdM}, 32'h0);
      RST_N = 1'b1; StallM = 1'b0;
      applyStimulus(4'h4, 32'hF0, 32'hFF, 32'h0, 1'b0, 5'd8);
      tick();
      checkOutput("post_rst_xor", ALUResultM, 32'h0F);
      checkOutput("post_rst_rd", {27'b0, RdM}, 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register. It consumes the decode/execute register outputs and applies operand forwarding. It computes the ALU result, resolves branches and jumps, and drives PC redirect to fetch. Results are registered into the memory stage, with stall and flush control from the hazard unit.

Parameters:
WIDTH, 32, datapath width in bits

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, funct3LSBE, funct3MSBE  in  1 each  execute-stage controls
ResultSrcE  in  2  writeback select
TypeE  in  3  branch condition code (funct3)
ALUControlE  in  4  ALU operation
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  WIDTH each  operands, PC, immediate, PC+4
RdE  in  5  destination register
ForwardAE, ForwardBE  in  2 each  00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE
ResultW  in  WIDTH  writeback-stage result
StallM  in  1  hold EX/MEM register
FlushM  in  1  insert bubble into EX/MEM
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  WIDTH  redirect target (combinational)
RegWriteM, MemWriteM, funct3LSBM, funct3MSBM  out  1 each  registered controls
ResultSrcM  out  2  registered writeback select
ALUResultM, WriteDataM, PCPlus4M  out  WIDTH each  registered data
RdM  out  5  registered destination

Behaviour:
- SrcA = ForwardAE mux. FwdB = ForwardBE mux. SrcB = ALUSrcE ? ImmExtE : FwdB.
- ALU ops: 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed, result 0/1); 0110 SLTU; 0111 SLL; 1000 SRL; 1001 SRA; 1010 pass SrcB (LUI). All others give 0.
- Shift amount is SrcB[4:0]. Add and subtract wrap modulo 2^WIDTH with no overflow flag.
- Branch compare always uses SrcA vs FwdB, independent of ALUSrcE:
  - 000 BEQ; 001 BNE; 100 BLT (signed); 101 BGE (signed); 110 BLTU; 111 BGEU.
  - 010 and 011 are never taken.
- PCSrcE = JumpE | (BranchE & taken).
- PCTargetE = JumpRegE ? ((SrcA + ImmExtE) & ~1) : (PCE + ImmExtE).
- PCSrcE and PCTargetE are purely combinational, with zero-cycle latency to fetch.
- EX/MEM register updates on the rising edge of CLK. Priority is RST_N low > FlushM > StallM > load.
  - Reset: every registered output = 0.
  - Flush: every registered output = 0. RegWriteM = 0 and MemWriteM = 0 guarantee no architectural side effect.
  - Stall: all registered outputs hold their value.
  - Load: RegWriteM ← RegWriteE, ResultSrcM ← ResultSrcE, MemWriteM ← MemWriteE, funct3 bits ← E versions, ALUResultM ← ALU output, WriteDataM ← FwdB (store data is forwarded, not RD2E), RdM ← RdE, PCPlus4M ← PCPlus4E.
- Latency: one cycle from E inputs to M outputs.
- ALUResultM feeds its own forwarding mux from the registered value. This path is sequential, so there is no combinational loop.
- Simultaneous FlushM and StallM: flush wins.
- Reset asserted mid-stall clears state on that edge. The first cycle after RST_N rises loads normally.
- PCSrcE is not gated by StallM or FlushM; the hazard unit qualifies it.
- Branch or jump with RdE = 0 still loads; writeback ignores x0.

Test Plan:
- Reset: hold RST_N = 0 for 2 cycles with arbitrary inputs -> all M outputs 0. Release -> next edge loads ADD of RD1E = 5, RD2E = 7 -> ALUResultM = 12, RdM matches RdE.
- ALU sweep with SrcA = 0x80000000, SrcB = 1 -> SUB = 0x7FFFFFFF, SLT = 1, SLTU = 0, SRA = 0xC0000000, SRL = 0x40000000, SLL = 0x00000000; code 1111 -> 0.
- Forwarding: RD1E = 1, ALUResultM = 0x10, ResultW = 0x20, ForwardAE = 10, ForwardBE = 01, ADD -> ALUResultM = 0x30; store -> WriteDataM = 0x20.
- Branch: BranchE = 1, TypeE = 100, SrcA = -1, FwdB = 0, PCE = 0x100, Imm = 0x20 -> PCSrcE = 1, PCTargetE = 0x120. Same with TypeE = 110 -> PCSrcE = 0.
- JALR: JumpE = JumpRegE = 1, SrcA = 0x1003, Imm = 4 -> PCTargetE = 0x1006, PCSrcE = 1, PCPlus4M = PCPlus4E after the edge.
- Stall/flush: load a valid store, then StallM = 1 for 3 cycles -> outputs hold. Then FlushM = StallM = 1 -> MemWriteM = RegWriteM = 0, all data 0.
